alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Iterative sequencer for the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Does shift-add multiply and restoring divide in W iterations, borrowing the shared
//  ALU adder through a req/gnt port; the integer pipeline has priority on that adder.
//  Sits beside the ALU in EX; the pipeline stalls on busy and picks up resp_data.
// PARAMETERS
//  W      32   operand/result width; adder port is W+2 wide, matching the ALU adder
//  CNT_W  6    iteration counter width, >= clog2(W)+1
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset, synchronous, active-high
//  flush        in   1     abort current op; no response is produced
//  req_valid    in   1     new M-op offered
//  req_ready    out  1     sequencer idle and able to accept (combinational from state)
//  req_op       in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_lhs      in   W     rs1 value
//  req_rhs      in   W     rs2 value
//  resp_valid   out  1     result valid; held until resp_ready
//  resp_ready   in   1     consumer takes result
//  resp_data    out  W     result
//  busy         out  1     op accepted and response not yet consumed
//  alu_req      out  1     sequencer wants the shared adder this cycle
//  alu_gnt      in   1     adder granted this cycle (combinational from arbiter)
//  alu_lhs      out  W+2   adder lhs, zero-extended
//  alu_rhs      out  W+2   adder rhs, zero-extended
//  alu_inv_rhs  out  1     1: ALU returns alu_lhs - alu_rhs; 0: alu_lhs + alu_rhs
//  alu_sum      in   W+2   adder result, same cycle
// BEHAVIOUR
//  Reset: state IDLE; resp_valid=0, resp_data=0, busy=0, alu_req=0; internal regs 0.
//  States: IDLE -> ITER -> FIX -> DONE -> IDLE. Accept = req_valid & req_ready & !flush.
//  IDLE: req_ready=1. On accept: latch op; signed ops (MULH lhs+rhs, MULHSU lhs only,
//   DIV/REM both) store |operand| via local negation and record result sign
//   (mul: sa^sb; div quotient: sa^sb; rem: sa). Counter loaded with W. -> ITER.
//  Special cases on accept, no ITER (resp_valid asserted on the next edge, -> DONE):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> lhs.
//   DIV/REM with lhs=0x8000_0000, rhs=all ones: DIV -> 0x8000_0000, REM -> 0.
//  ITER: alu_req=1. Advances only in cycles with alu_gnt=1; otherwise all regs hold.
//   Mul: if prod_lo[0], hi_next = alu_sum (hi + mcand, inv_rhs=0), else hi; then
//     {hi,lo} shifted right 1 with alu_sum[W] as carry-in to the top.
//   Div: rem' = {rem[W-2:0], dvd[W-1]}; alu computes rem' - dvs (inv_rhs=1);
//     alu_sum[W+1]=0 -> rem=alu_sum[W-1:0], quotient bit 1; else rem=rem', bit 0.
//   Counter decrements per granted cycle; leaves ITER after the W-th granted cycle.
//  FIX (1 cycle, no adder): negate 2W product / quotient / remainder if sign set;
//   select low W (MUL), high W (MULH*), quotient (DIV*) or remainder (REM*); -> DONE.
//  DONE: resp_valid=1, resp_data stable; resp_ready -> IDLE same edge.
//  Latency with alu_gnt held high: resp_valid rises W+2 edges after accept edge;
//   each non-granted ITER cycle adds exactly one.
//  alu_req=0 outside ITER; alu_lhs/alu_rhs/alu_inv_rhs are don't-care when alu_req=0.
//  flush: any state -> IDLE next edge, resp_valid=0, busy=0; no accept in a flush cycle.
//  rst mid-op behaves as flush plus register clear. No back-to-back accept in DONE.
// CONFIGURATION
//  MULDIV_ZERO_SKIP_EN defined: MUL* with either operand 0 skips ITER; result 0 is
//   valid 1 edge after accept, like the div special cases.
//  Undefined: zero multiplies take the full W+2 latency; results are identical.
// TESTING
//  MUL 7 x 6, gnt=1 -> resp_data=42, resp_valid exactly 34 edges after accept.
//  MULHU/MULH/MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE / 0x00000000 / 0xFFFFFFFF.
//  DIV/REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFD / 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; all 1-edge latency.
//  alu_gnt low for 5 cycles mid-ITER -> regs frozen, latency 39; resp_ready low 3 cycles
//   in DONE -> resp_data and resp_valid held until taken.
//  flush at ITER count 10 -> no resp_valid, req_ready=1 next cycle; a fresh MUL 3x3 -> 9.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide sequencer.
// Uses shift-add multiply and restoring divide, one step per granted cycle
// on the shared ALU adder.
// Optional build macro MULDIV_ZERO_SKIP_EN: multiplies with a zero operand
// finish one edge after accept instead of iterating.
//
// state | meaning
// IDLE  | ready for a new op
// ITER  | one multiply/divide step per granted adder cycle
// FIX   | sign correction and result select
// DONE  | result presented until consumed
module alu_muldiv_seq #(
   parameter int W     = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [2:0]     req_op,
   input  logic [W-1:0]   req_lhs,
   input  logic [W-1:0]   req_rhs,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [W-1:0]   resp_data,
   output logic           busy,
   output logic           alu_req,
   input  logic           alu_gnt,
   output logic [W+1:0]   alu_lhs,
   output logic [W+1:0]   alu_rhs,
   output logic           alu_inv_rhs,
   input  logic [W+1:0]   alu_sum
);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state;
   logic [2:0]       op;
   logic [W-1:0]     hi;     // product high half / partial remainder
   logic [W-1:0]     lo;     // multiplier shifting out / dividend shifting into quotient
   logic [W-1:0]     opb;    // multiplicand / divisor magnitude
   logic             sign;   // final result must be negated
   logic [CNT_W-1:0] cnt;

   logic             lhs_signed, rhs_signed, sa, sb, res_sign;
   logic [W-1:0]     lhs_mag, rhs_mag;
   logic             special;
   logic [W-1:0]     special_data;
   logic [W-1:0]     hi_n, lo_n;
   logic [W:0]       mul_acc;
   logic [2*W-1:0]   prod_fix;
   logic [W-1:0]     q_fix, r_fix, fix_data;

   assign req_ready = (state == IDLE);

   // Operand magnitudes and result sign, decoded from the offered request
   always_comb begin
      lhs_signed = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
      rhs_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
      sa         = lhs_signed & req_lhs[W-1];
      sb         = rhs_signed & req_rhs[W-1];
      lhs_mag    = sa ? -req_lhs : req_lhs;
      rhs_mag    = sb ? -req_rhs : req_rhs;
      case (req_op)
         3'd1, 3'd4: res_sign = sa ^ sb;
         3'd2, 3'd6: res_sign = sa;
         default:    res_sign = 1'b0;
      endcase
   end

   // Cases answered directly at accept without iterating
   always_comb begin
      special      = 1'b0;
      special_data = '0;
      if (req_op[2] && (req_rhs == '0)) begin
         special      = 1'b1;
         special_data = req_op[1] ? req_lhs : '1;
      end else if (!req_op[0] && req_op[2] && (req_lhs == {1'b1, {(W-1){1'b0}}}) && (&req_rhs)) begin
         special      = 1'b1;
         special_data = req_op[1] ? '0 : req_lhs;
      end
`ifdef MULDIV_ZERO_SKIP_EN
      else if (!req_op[2] && ((req_lhs == '0) || (req_rhs == '0))) begin
         special      = 1'b1;
         special_data = '0;
      end
`endif
   end

   // Adder operands and the next iteration step
   always_comb begin
      mul_acc = lo[0] ? alu_sum[W:0] : {1'b0, hi};
      if (!op[2]) begin
         alu_lhs     = {2'b00, hi};
         alu_rhs     = {2'b00, opb};
         alu_inv_rhs = 1'b0;
         hi_n        = mul_acc[W:1];
         lo_n        = {mul_acc[0], lo[W-1:1]};
      end else begin
         // shifted remainder is W+1 bits so large divisors cannot overflow it
         alu_lhs     = {1'b0, hi, lo[W-1]};
         alu_rhs     = {2'b00, opb};
         alu_inv_rhs = 1'b1;
         if (!alu_sum[W+1]) begin
            hi_n = alu_sum[W-1:0];
            lo_n = {lo[W-2:0], 1'b1};
         end else begin
            hi_n = {hi[W-2:0], lo[W-1]};
            lo_n = {lo[W-2:0], 1'b0};
         end
      end
   end

   // Sign fix-up and result selection
   always_comb begin
      prod_fix = sign ? -{hi, lo} : {hi, lo};
      q_fix    = sign ? -lo : lo;
      r_fix    = sign ? -hi : hi;
      case (op)
         3'd0:             fix_data = prod_fix[W-1:0];
         3'd1, 3'd2, 3'd3: fix_data = prod_fix[2*W-1:W];
         3'd4, 3'd5:       fix_data = q_fix;
         default:          fix_data = r_fix;
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op         <= '0;
         hi         <= '0;
         lo         <= '0;
         opb        <= '0;
         sign       <= 1'b0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         busy       <= 1'b0;
         alu_req    <= 1'b0;
      end else if (flush) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         busy       <= 1'b0;
         alu_req    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op   <= req_op;
                  sign <= res_sign;
                  busy <= 1'b1;
                  cnt  <= CNT_W'(W);
                  if (special) begin
                     resp_data  <= special_data;
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     hi      <= '0;
                     lo      <= req_op[2] ? lhs_mag : rhs_mag;
                     opb     <= req_op[2] ? rhs_mag : lhs_mag;
                     alu_req <= 1'b1;
                     state   <= ITER;
                  end
               end
            end
            ITER: begin
               if (alu_gnt) begin
                  hi  <= hi_n;
                  lo  <= lo_n;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     alu_req <= 1'b0;
                     state   <= FIX;
                  end
               end
            end
            FIX: begin
               resp_data  <= fix_data;
               resp_valid <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq: directed RV32M vectors, adder stalls,
// response back-pressure, flush/reset aborts and randomized ops against an
// arithmetic reference model. The shared adder is modelled behaviourally.
module tb_alu_muldiv_seq;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
   logic [2:0]    req_op;
   logic [W-1:0]  req_lhs, req_rhs, resp_data;
   logic          alu_req, alu_gnt, alu_inv_rhs;
   logic [W+1:0]  alu_lhs, alu_rhs, alu_sum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb alu_sum = alu_inv_rhs ? (alu_lhs - alu_rhs) : (alu_lhs + alu_rhs);

   alu_muldiv_seq #(.W(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_lhs(req_lhs), .req_rhs(req_rhs),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .busy(busy), .alu_req(alu_req), .alu_gnt(alu_gnt),
      .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_inv_rhs(alu_inv_rhs), .alu_sum(alu_sum)
   );

   // RV32M results from plain arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int          ia, ib;
      longint      la, lb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      ia = a; ib = b;
      la = ia; lb = ib;
      ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
      case (op)
         3'd0: begin p = ua * ub; r = p[31:0];  end
         3'd1: begin p = la * lb; r = p[63:32]; end
         3'd2: begin p = la * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stalls);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
      if (!op[2] && (a == 0 || b == 0)) return 1;
`endif
      return W + 2 + stalls;
   endfunction

   // Drives one op to completion and reports what was observed.
   // lat counts edges from the accept edge (inclusive) to the first edge
   // after which resp_valid is seen high.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int gnt_pct, input int stall_at, input int stall_len, input int hold,
                         output logic [31:0] data, output int lat, output int stalls,
                         output bit tmo, output bit frozen_ok, output bit hold_ok, output bit done_rdy);
      int           iter_n;
      logic [W+1:0] frz;
      bit           have_frz;
      tmo = 0; stalls = 0; iter_n = 0; frozen_ok = 1; hold_ok = 1; done_rdy = 0; have_frz = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_lhs = a; req_rhs = b; alu_gnt = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!resp_valid) begin
         if (lat > 300) begin tmo = 1; break; end
         if (alu_req) begin
            if (iter_n >= stall_at && iter_n < stall_at + stall_len) begin
               alu_gnt = 1'b0;
               if (have_frz && alu_lhs !== frz) frozen_ok = 0;
               frz = alu_lhs; have_frz = 1;
            end else begin
               alu_gnt = ($urandom_range(99) < gnt_pct);
            end
            if (!alu_gnt) stalls++;
            iter_n++;
         end else begin
            alu_gnt = 1'($urandom_range(1));
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      data     = resp_data;
      done_rdy = req_ready;
      alu_gnt  = 1'b1;
      if (tmo) begin
         flush = 1'b1;
         @(posedge clk);
         @(negedge clk);
         flush = 1'b0;
      end else begin
         for (int i = 0; i < hold; i++) begin
            resp_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (!resp_valid || resp_data !== data || !busy) hold_ok = 0;
         end
         resp_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         resp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; alu_gnt = 1'b1;
      req_op = '0; req_lhs = '0; req_rhs = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
      total++; if (resp_data !== '0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL reset_alu_req got=%b want=0", alu_req); end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op  [11] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
      logic [31:0] t_a   [11] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
      logic [31:0] t_b   [11] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] t_exp [11] = '{32'd42, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
      int          t_lat [11] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1};
      logic [31:0] data;
      int          lat, stalls;
      bit          tmo, frz, hold_ok, drdy;
      for (int i = 0; i < 11; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], 100, 0, 0, 0, data, lat, stalls, tmo, frz, hold_ok, drdy);
         total++; if (tmo) begin bad++; $display("FAIL dir%0d_timeout got=no resp want=resp", i); end
         total++; if (data !== t_exp[i]) begin bad++; $display("FAIL dir%0d_data op=%0d got=%h want=%h", i, t_op[i], data, t_exp[i]); end
         total++; if (lat != t_lat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, t_lat[i]); end
         total++; if (drdy !== 1'b0) begin bad++; $display("FAIL dir%0d_ready_in_done got=%b want=0", i, drdy); end
      end
   endtask

   task automatic test_stall_hold();
      logic [31:0] data, exp;
      int          lat, stalls;
      bit          tmo, frz, hold_ok, drdy;
      exp = ref_res(3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
      run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 100, 12, 5, 3, data, lat, stalls, tmo, frz, hold_ok, drdy);
      total++; if (data !== exp) begin bad++; $display("FAIL stall_data got=%h want=%h", data, exp); end
      total++; if (lat != 39) begin bad++; $display("FAIL stall_latency got=%0d want=39", lat); end
      total++; if (!frz) begin bad++; $display("FAIL stall_frozen got=changed want=held"); end
      total++; if (!hold_ok) begin bad++; $display("FAIL resp_hold got=dropped want=held"); end
   endtask

   task automatic test_flush();
      logic [31:0] data;
      int          lat, stalls;
      bit          tmo, frz, hold_ok, drdy, seen;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_lhs = 32'h1357_9BDF; req_rhs = 32'h2468_ACE0; alu_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (22) begin @(posedge clk); @(negedge clk); end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_resp_valid got=%b want=0", resp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_req_ready got=%b want=1", req_ready); end
      total++; if (busy !== 1'b0 || alu_req !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b%b want=00", busy, alu_req); end
      seen = 0;
      repeat (40) begin @(posedge clk); @(negedge clk); if (resp_valid) seen = 1; end
      total++; if (seen) begin bad++; $display("FAIL flush_no_resp got=resp want=none"); end
      // flush and request together must not accept
      req_valid = 1'b1; req_op = 3'd5; req_lhs = 32'd9; req_rhs = 32'd0; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept got=%b%b want=00", busy, resp_valid); end
      run_op(3'd0, 32'd3, 32'd3, 100, 0, 0, 0, data, lat, stalls, tmo, frz, hold_ok, drdy);
      total++; if (data !== 32'd9 || lat != 34) begin bad++; $display("FAIL after_flush_mul got=%h/%0d want=00000009/34", data, lat); end
      // reset mid-op aborts and clears the held result
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd4; req_lhs = 32'd1000; req_rhs = 32'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (8) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== '0 || req_ready !== 1'b1)
         begin bad++; $display("FAIL midop_reset got=v%b b%b d%h r%b want=v0 b0 d0 r1", resp_valid, busy, resp_data, req_ready); end
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(100));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, data, exp;
      int          lat, stalls, elat;
      bit          tmo, frz, hold_ok, drdy;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(7));
         a  = pick_val();
         b  = pick_val();
         run_op(op, a, b, 75, 0, 0, $urandom_range(2), data, lat, stalls, tmo, frz, hold_ok, drdy);
         exp  = ref_res(op, a, b);
         elat = ref_lat(op, a, b, stalls);
         total++; if (tmo || data !== exp) begin bad++; $display("FAIL rnd%0d_data op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, data, exp); end
         total++; if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", i, op, lat, elat); end
         total++; if (!hold_ok) begin bad++; $display("FAIL rnd%0d_hold got=dropped want=held", i); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall_hold();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
